// File: rtl/srff_bank_ctrl_if.sv
// Bundle between the SR-bank sequencer, its requesters and the external flop bank.
// The master side drives requests and flop feedback; the slave side is the sequencer.
interface srff_bank_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IW    = 3
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [IW*NREQ-1:0] idx;
    logic [NREQ-1:0]    gnt;
    logic [NFLAG-1:0]   s_out;
    logic [NFLAG-1:0]   r_out;
    logic [NFLAG-1:0]   q_in;
    logic               busy;
    logic               done;
    logic               err;
    logic [7:0]         err_cnt;

    modport master (
        output req, op, idx, q_in,
        input  gnt, s_out, r_out, busy, done, err, err_cnt
    );

    modport slave (
        input  req, op, idx, q_in,
        output gnt, s_out, r_out, busy, done, err, err_cnt
    );
endinterface

// File: rtl/srff_bank_ctrl.sv
// Round-robin sequencer that pulses set/reset onto a bank of external SR flops and
// verifies the flop output one cycle later; S and R are never driven together.
module srff_bank_ctrl #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    srff_bank_ctrl_if.slave  bus
);
    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;
    localparam logic [1:0] CHECK = 2'd3;

    localparam logic [1:0] CLS_HOLD = 2'd0;
    localparam logic [1:0] CLS_SET  = 2'd1;
    localparam logic [1:0] CLS_RST  = 2'd2;
    localparam logic [1:0] CLS_ILL  = 2'd3;

    logic [1:0]       state_r;
    logic [PW-1:0]    ptr_r;
    logic [1:0]       op_r;
    logic [IW-1:0]    idx_r;
    logic [1:0]       cls_r;
    logic [NREQ-1:0]  gnt_r;
    logic [NFLAG-1:0] s_r;
    logic [NFLAG-1:0] r_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [7:0]       err_cnt_r;

    logic             found_s;
    logic [PW-1:0]    win_s;
    logic [PW-1:0]    ptr_nxt_s;
    logic [NREQ-1:0]  win_oh_s;
    logic [1:0]       win_op_s;
    logic [IW-1:0]    win_idx_s;
    logic [NFLAG-1:0] sel_s;
    logic [1:0]       cls_nxt_s;
    logic             q_bit_s;
    logic             chk_ok_s;

    function automatic int wrap_idx(input int v);
        if (v >= NREQ) begin
            return v - NREQ;
        end else begin
            return v;
        end
    endfunction

    // round-robin search starting at the pointer, plus the winner's command fields
    always_comb begin
        found_s   = 1'b0;
        win_s     = '0;
        win_oh_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && bus.req[wrap_idx(int'(ptr_r) + k)]) begin
                found_s = 1'b1;
                win_s   = PW'(wrap_idx(int'(ptr_r) + k));
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            win_oh_s[i] = (int'(win_s) == i);
        end
        ptr_nxt_s = (int'(win_s) == NREQ - 1) ? '0 : win_s + PW'(1);
        win_op_s  = bus.op[2*int'(win_s) +: 2];
        win_idx_s = bus.idx[IW*int'(win_s) +: IW];
    end

    // decode the captured command and its target flag
    always_comb begin
        sel_s = '0;
        for (int f = 0; f < NFLAG; f++) begin
            sel_s[f] = (int'(idx_r) == f);
        end
        if (op_r == 2'b11 || int'(idx_r) >= NFLAG) begin
            cls_nxt_s = CLS_ILL;
        end else if (op_r == 2'b01) begin
            cls_nxt_s = CLS_SET;
        end else if (op_r == 2'b10) begin
            cls_nxt_s = CLS_RST;
        end else begin
            cls_nxt_s = CLS_HOLD;
        end
        q_bit_s = |(bus.q_in & sel_s);
        case (cls_r)
            CLS_SET:  chk_ok_s = q_bit_s;
            CLS_RST:  chk_ok_s = !q_bit_s;
            CLS_HOLD: chk_ok_s = 1'b1;
            default:  chk_ok_s = 1'b0;
        endcase
    end

    // sequencer FSM; pulse outputs default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            op_r      <= 2'b00;
            idx_r     <= '0;
            cls_r     <= CLS_HOLD;
            gnt_r     <= '0;
            s_r       <= '0;
            r_r       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            gnt_r  <= '0;
            s_r    <= '0;
            r_r    <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (|bus.req) begin
                        state_r <= GRANT;
                        busy_r  <= 1'b1;
                        gnt_r   <= win_oh_s;
                        op_r    <= win_op_s;
                        idx_r   <= win_idx_s;
                        ptr_r   <= ptr_nxt_s;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    state_r <= APPLY;
                    busy_r  <= 1'b1;
                    cls_r   <= cls_nxt_s;
                    s_r     <= (cls_nxt_s == CLS_SET) ? sel_s : '0;
                    r_r     <= (cls_nxt_s == CLS_RST) ? sel_s : '0;
                end
                APPLY: begin
                    state_r <= CHECK;
                    busy_r  <= 1'b1;
                end
                CHECK: begin
                    done_r <= chk_ok_s;
                    err_r  <= !chk_ok_s;
                    if (!chk_ok_s && err_cnt_r != 8'hFF) begin
                        err_cnt_r <= err_cnt_r + 8'd1;
                    end else begin
                        err_cnt_r <= err_cnt_r;
                    end
                    // back-to-back: arbitrate straight out of CHECK
                    if (|bus.req) begin
                        state_r <= GRANT;
                        busy_r  <= 1'b1;
                        gnt_r   <= win_oh_s;
                        op_r    <= win_op_s;
                        idx_r   <= win_idx_s;
                        ptr_r   <= ptr_nxt_s;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.s_out   = s_r;
    assign bus.r_out   = r_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.err_cnt = err_cnt_r;
endmodule

// File: tb/tb_srff_bank_ctrl.sv
// Directed bench for srff_bank_ctrl with a behavioural SR flop bank on the same clock.
// Stimulus and sampling happen on the falling edge.
module tb_srff_bank_ctrl;
  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [NFLAG-1:0] fq = '0;
  logic [NFLAG-1:0] q_flip = '0;

  srff_bank_ctrl_if #(.NREQ(NREQ), .NFLAG(NFLAG), .IW(IW)) bus ();

  srff_bank_ctrl #(.NREQ(NREQ), .NFLAG(NFLAG), .IW(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // external flop bank; keeps its state through controller reset
  always @(posedge clk) begin
    for (int f = 0; f < NFLAG; f++) begin
      if (bus.s_out[f]) fq[f] <= 1'b1;
      else if (bus.r_out[f]) fq[f] <= 1'b0;
    end
  end

  assign bus.q_in = fq ^ q_flip;

  task automatic do_cmd(input int rq, input logic [1:0] o, input logic [IW-1:0] ix,
                        input logic [NFLAG-1:0] flip,
                        output logic [NREQ-1:0] g, output logic [NFLAG-1:0] s_ap,
                        output logic [NFLAG-1:0] r_ap, output logic [NFLAG-1:0] sr_ck,
                        output logic early, output logic d, output logic e);
    bus.req = '0;
    bus.req[rq] = 1'b1;
    bus.op[2*rq +: 2] = o;
    bus.idx[IW*rq +: IW] = ix;
    @(negedge clk);
    g = bus.gnt;
    bus.req = '0;
    @(negedge clk);
    s_ap = bus.s_out;
    r_ap = bus.r_out;
    q_flip = flip;
    @(negedge clk);
    sr_ck = bus.s_out | bus.r_out;
    early = bus.done | bus.err;
    @(negedge clk);
    d = bus.done;
    e = bus.err;
    q_flip = '0;
  endtask

  task automatic test_reset;
    bus.req = '0; bus.op = '0; bus.idx = '0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks += 7;
    if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt); end
    if (bus.s_out !== 8'h00) begin n_fail++; $display("FAIL rst_s: got %h want 00", bus.s_out); end
    if (bus.r_out !== 8'h00) begin n_fail++; $display("FAIL rst_r: got %h want 00", bus.r_out); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", bus.err_cnt); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_set_basic;
    logic [NREQ-1:0] g; logic [NFLAG-1:0] s_ap, r_ap, sr_ck; logic early, d, e;
    do_cmd(0, 2'b01, 4'd3, 8'h00, g, s_ap, r_ap, sr_ck, early, d, e);
    n_checks += 10;
    if (g !== 4'b0001) begin n_fail++; $display("FAIL set_gnt: got %b want 0001", g); end
    if (s_ap !== 8'h08) begin n_fail++; $display("FAIL set_s: got %h want 08", s_ap); end
    if (r_ap !== 8'h00) begin n_fail++; $display("FAIL set_r: got %h want 00", r_ap); end
    if (sr_ck !== 8'h00) begin n_fail++; $display("FAIL set_pulse_len: got %h want 00", sr_ck); end
    if (early !== 1'b0) begin n_fail++; $display("FAIL set_early: got %b want 0", early); end
    if (d !== 1'b1) begin n_fail++; $display("FAIL set_done: got %b want 1", d); end
    if (e !== 1'b0) begin n_fail++; $display("FAIL set_err: got %b want 0", e); end
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL set_cnt: got %0d want 0", bus.err_cnt); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL set_idle: got %b want 0", bus.busy); end
    if (bus.q_in[3] !== 1'b1) begin n_fail++; $display("FAIL set_q3: got %b want 1", bus.q_in[3]); end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_g;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    bus.op = 8'b01_01_01_01;
    bus.idx = 16'h3210;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << (n % 4);
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", n, bus.gnt, exp_g); end
      if (n > 0) begin
        n_checks++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rr_done%0d: got %b want 1", n, bus.done); end
      end
      if (n == 4) bus.req = '0;
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.gnt !== 4'b0000) begin
        n_fail++; $display("FAIL rr_apply%0d: got busy %b gnt %b want 1 0000", n, bus.busy, bus.gnt);
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rr_check%0d: got %b want 1", n, bus.busy); end
    end
    @(negedge clk);
    n_checks += 2;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rr_last_done: got %b want 1", bus.done); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_illegal;
    logic [NREQ-1:0] g; logic [NFLAG-1:0] s_ap, r_ap, sr_ck; logic early, d, e;
    do_cmd(1, 2'b11, 4'd2, 8'h00, g, s_ap, r_ap, sr_ck, early, d, e);
    n_checks += 5;
    if (g !== 4'b0010) begin n_fail++; $display("FAIL ill_op_gnt: got %b want 0010", g); end
    if ((s_ap | r_ap) !== 8'h00) begin n_fail++; $display("FAIL ill_op_sr: got %h want 00", s_ap | r_ap); end
    if (d !== 1'b0) begin n_fail++; $display("FAIL ill_op_done: got %b want 0", d); end
    if (e !== 1'b1) begin n_fail++; $display("FAIL ill_op_err: got %b want 1", e); end
    if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL ill_op_cnt: got %0d want 1", bus.err_cnt); end
    do_cmd(2, 2'b01, 4'd9, 8'h00, g, s_ap, r_ap, sr_ck, early, d, e);
    n_checks += 4;
    if ((s_ap | r_ap) !== 8'h00) begin n_fail++; $display("FAIL ill_idx_sr: got %h want 00", s_ap | r_ap); end
    if (d !== 1'b0) begin n_fail++; $display("FAIL ill_idx_done: got %b want 0", d); end
    if (e !== 1'b1) begin n_fail++; $display("FAIL ill_idx_err: got %b want 1", e); end
    if (bus.err_cnt !== 8'd2) begin n_fail++; $display("FAIL ill_idx_cnt: got %0d want 2", bus.err_cnt); end
    do_cmd(3, 2'b00, 4'd6, 8'h00, g, s_ap, r_ap, sr_ck, early, d, e);
    n_checks += 4;
    if ((s_ap | r_ap) !== 8'h00) begin n_fail++; $display("FAIL hold_sr: got %h want 00", s_ap | r_ap); end
    if (d !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b want 1", d); end
    if (e !== 1'b0) begin n_fail++; $display("FAIL hold_err: got %b want 0", e); end
    if (bus.err_cnt !== 8'd2) begin n_fail++; $display("FAIL hold_cnt: got %0d want 2", bus.err_cnt); end
  endtask

  task automatic test_mismatch;
    logic [NREQ-1:0] g; logic [NFLAG-1:0] s_ap, r_ap, sr_ck; logic early, d, e;
    do_cmd(0, 2'b01, 4'd5, 8'h20, g, s_ap, r_ap, sr_ck, early, d, e);
    n_checks += 4;
    if (s_ap !== 8'h20) begin n_fail++; $display("FAIL mis_s: got %h want 20", s_ap); end
    if (d !== 1'b0) begin n_fail++; $display("FAIL mis_done: got %b want 0", d); end
    if (e !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b want 1", e); end
    if (bus.err_cnt !== 8'd3) begin n_fail++; $display("FAIL mis_cnt: got %0d want 3", bus.err_cnt); end
    do_cmd(0, 2'b10, 4'd5, 8'h00, g, s_ap, r_ap, sr_ck, early, d, e);
    n_checks += 6;
    if (r_ap !== 8'h20) begin n_fail++; $display("FAIL clr_r: got %h want 20", r_ap); end
    if (s_ap !== 8'h00) begin n_fail++; $display("FAIL clr_s: got %h want 00", s_ap); end
    if (d !== 1'b1) begin n_fail++; $display("FAIL clr_done: got %b want 1", d); end
    if (e !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b want 0", e); end
    if (bus.err_cnt !== 8'd3) begin n_fail++; $display("FAIL clr_cnt: got %0d want 3", bus.err_cnt); end
    if (bus.q_in[5] !== 1'b0) begin n_fail++; $display("FAIL clr_q5: got %b want 0", bus.q_in[5]); end
  endtask

  task automatic test_reset_apply;
    bus.req = 4'b0001;
    bus.op[1:0] = 2'b01;
    bus.idx[3:0] = 4'd2;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    n_checks++;
    if (bus.s_out !== 8'h04) begin n_fail++; $display("FAIL ra_s_apply: got %h want 04", bus.s_out); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (bus.s_out !== 8'h00) begin n_fail++; $display("FAIL ra_s_async: got %h want 00", bus.s_out); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ra_busy: got %b want 0", bus.busy); end
    if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL ra_gnt: got %b want 0000", bus.gnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks += 4;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL ra_pulse: got done %b err %b want 0 0", bus.done, bus.err);
    end
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL ra_cnt: got %0d want 0", bus.err_cnt); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ra_idle: got %b want 0", bus.busy); end
    if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL ra_gnt_after: got %b want 0000", bus.gnt); end
  endtask

  task automatic test_saturate;
    int n_err;
    int exp_cnt;
    n_err = 0;
    bus.req = 4'b0001;
    bus.op[1:0] = 2'b11;
    bus.idx[3:0] = 4'd0;
    for (int c = 0; c < 1000 && n_err < 260; c++) begin
      @(negedge clk);
      n_checks++;
      if ((bus.s_out & bus.r_out) !== 8'h00) begin
        n_fail++; $display("FAIL sat_sr_c%0d: got %h want 00", c, bus.s_out & bus.r_out);
      end
      if (bus.err === 1'b1) begin
        n_err++;
        exp_cnt = (n_err > 255) ? 255 : n_err;
        n_checks++;
        if (bus.err_cnt !== exp_cnt[7:0]) begin
          n_fail++; $display("FAIL sat_cnt%0d: got %0d want %0d", n_err, bus.err_cnt, exp_cnt);
        end
        if (n_err == 259) bus.req = '0;
      end
    end
    n_checks++;
    if (n_err != 260) begin n_fail++; $display("FAIL sat_timeout: got %0d errors want 260", n_err); end
    @(negedge clk);
    n_checks += 2;
    if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", bus.err_cnt); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sat_idle: got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_set_basic();
    test_round_robin();
    test_illegal();
    test_mismatch();
    test_reset_apply();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/srff_bank_ctrl.md
Name: srff_bank_ctrl

Overview:
Arbitrated sequencer for a bank of NFLAG external SR flip-flops that all share the same clock CLK. Up to NREQ requesters issue set, reset or hold commands against one flag each. Round-robin arbitration picks one command at a time. The block drives the SR inputs as a one-cycle pulse, then checks the flop's Q on the following cycle. It also rejects the forbidden S=R=1 condition before it can reach the flops.

Parameters:
NREQ, 4, number of requesters (2..8)
NFLAG, 8, number of SR flip-flops in the controlled bank (1..16)
IW, 3, flag index width per requester; must be >= clog2(NFLAG)

Ports:
CLK  in  1  single clock; rising edge
RST_N  in  1  asynchronous, active-low reset
REQ  in  NREQ  per-requester request; held high until granted
OP  in  2*NREQ  requester i command at [2i+1:2i]: 00 hold, 01 set, 10 reset, 11 illegal
IDX  in  IW*NREQ  requester i target flag at [IW*i+IW-1:IW*i]
GNT  out  NREQ  one-hot grant, high for exactly one cycle
S_OUT  out  NFLAG  S inputs to the flop bank
R_OUT  out  NFLAG  R inputs to the flop bank
Q_IN  in  NFLAG  Q outputs from the flop bank
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse: command completed and checked OK
ERR  out  1  one-cycle pulse: command rejected or check mismatch
ERR_CNT  out  8  saturating error count

Behaviour:
- Reset (RST_N=0, takes effect immediately without waiting for a clock edge):
  - state=IDLE, round-robin pointer=0.
  - GNT, S_OUT, R_OUT, DONE, ERR = 0; ERR_CNT = 0.
  - Reset asserted mid-command aborts the command. S_OUT/R_OUT drop at once; the flop bank keeps whatever it last latched.
- FSM states: IDLE, GRANT, APPLY, CHECK. All outputs are registered.
- IDLE:
  - If REQ != 0 at a CLK edge, go to GRANT.
  - On that same edge: set GNT to the winner (one-hot), capture the winner's OP and IDX, and set pointer = winner+1 mod NREQ.
- Arbitration: round-robin. Search starts at the pointer. The first i (ascending, wrapping) with REQ[i]=1 wins.
- GRANT (1 cycle): GNT high. Next state is always APPLY. The requester may drop REQ or present a new command from the next cycle.
- Command classification, decided when entering APPLY:
  - Legal: OP in {01, 10} and IDX < NFLAG.
  - Hold: OP = 00.
  - Illegal: OP = 11, or IDX >= NFLAG.
- APPLY (1 cycle):
  - Legal set: S_OUT[IDX]=1, all other S/R bits 0.
  - Legal reset: R_OUT[IDX]=1, all other S/R bits 0.
  - Hold or illegal: S_OUT=R_OUT=0.
  - S_OUT & R_OUT is 0 in every cycle, by construction.
  - Next state is CHECK.
- CHECK (1 cycle): Q_IN is sampled; the flop updated on the edge that ended APPLY.
  - Set and Q_IN[IDX]=1, reset and Q_IN[IDX]=0, or hold: DONE=1.
  - Illegal command, or Q_IN[IDX] mismatch: ERR=1 and ERR_CNT increments, saturating at 255.
  - DONE and ERR are never both high.
- Leaving CHECK: if REQ != 0, arbitrate and go straight to GRANT (back-to-back). Otherwise go to IDLE.
- Timing:
  - Request-to-DONE/ERR latency from IDLE is 3 edges (REQ sampled at edge 0, GNT after edge 0, APPLY after edge 1, CHECK after edge 2).
  - Sustained throughput is one command per 3 cycles.
- REQ raised by a new requester during GRANT, APPLY or CHECK waits for the next arbitration. No request is lost while it is held.
- A requester that drops REQ before it is granted is simply not serviced.
- BUSY = (state != IDLE).

Test Plan:
1. Reset, then REQ=0001, OP0=01, IDX0=3 -> GNT=0001 after edge 1; S_OUT=0x08 for one cycle; Q_IN[3]=1; DONE pulse 3 edges after REQ; ERR_CNT=0.
2. REQ=1111 held continuously, all ops legal -> grants in order 0001, 0010, 0100, 1000, 0001, one every 3 cycles; BUSY stays high; no IDLE between commands.
3. OP=11 on a flag, then separately IDX=9 with NFLAG=8 -> S_OUT=R_OUT=0 throughout; two ERR pulses; ERR_CNT=2; no DONE.
4. Set flag 5, then a bench-forced Q_IN[5]=0 during CHECK -> ERR pulse, ERR_CNT+1; a following reset command on flag 5 completes with DONE.
5. Assert RST_N=0 during APPLY of a set on flag 2 -> S_OUT goes to 0 immediately; state IDLE; GNT/DONE/ERR stay 0; ERR_CNT=0 after release.
6. 260 illegal commands back-to-back -> ERR_CNT saturates at 255 and stays there; S_OUT & R_OUT == 0 asserted every cycle.
